// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: ALU op codes and register-index constants.
package mips_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

    // Shift operations are the codes with bit 3 set.
    typedef enum logic [3:0] {
        AluAdd = 4'h0,
        AluSub = 4'h1,
        AluAnd = 4'h2,
        AluOr  = 4'h3,
        AluXor = 4'h4,
        AluLui = 4'h5,
        AluSll = 4'h8,
        AluSrl = 4'h9,
        AluSra = 4'hA
    } alu_op_e;

endpackage

// File: rtl/forward_mux.sv
// Per-operand forwarding select: EX/MEM beats MEM/WB beats the captured register value.
module forward_mux
    import mips_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned RegAddrWidth = REG_ADDR_WIDTH
) (
    input  logic [RegAddrWidth-1:0] src_i,
    input  logic [DataWidth-1:0]    reg_data_i,
    input  logic                    ex_mem_reg_write_i,
    input  logic                    ex_mem_mem_read_i,
    input  logic [RegAddrWidth-1:0] ex_mem_rd_i,
    input  logic [DataWidth-1:0]    ex_mem_result_i,
    input  logic                    mem_wb_reg_write_i,
    input  logic [RegAddrWidth-1:0] mem_wb_rd_i,
    input  logic [DataWidth-1:0]    mem_wb_data_i,
    output logic [DataWidth-1:0]    fwd_data_o
);

    logic src_nonzero;
    assign src_nonzero = (src_i != RegAddrWidth'(ZERO_REG));

    // A load in EX/MEM has no data yet; the hazard logic stalls instead.
    always_comb begin
        fwd_data_o = reg_data_i;
        if (ex_mem_reg_write_i && !ex_mem_mem_read_i && (ex_mem_rd_i == src_i) && src_nonzero) begin
            fwd_data_o = ex_mem_result_i;
        end else if (mem_wb_reg_write_i && (mem_wb_rd_i == src_i) && src_nonzero) begin
            fwd_data_o = mem_wb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands, resolves forwarding and load-use stalls,
// and presents ALU operands plus downstream control behind a valid/ready handshake.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned RegAddrWidth = REG_ADDR_WIDTH
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic                    Flush,
    input  logic [DataWidth-1:0]    RsData,
    input  logic [DataWidth-1:0]    RtData,
    input  logic [RegAddrWidth-1:0] Rs,
    input  logic [RegAddrWidth-1:0] Rt,
    input  logic [RegAddrWidth-1:0] Rd,
    input  logic [15:0]             Imm16,
    input  logic [4:0]              Shamt,
    input  logic [3:0]              InALUControl,
    input  logic                    ALUSrcImm,
    input  logic                    SignExt,
    input  logic                    IsShift,
    input  logic                    InRegWrite,
    input  logic                    InMemRead,
    input  logic                    InMemWrite,
    input  logic                    ExMemRegWrite,
    input  logic                    ExMemMemRead,
    input  logic [RegAddrWidth-1:0] ExMemRd,
    input  logic [DataWidth-1:0]    ExMemResult,
    input  logic                    MemWbRegWrite,
    input  logic [RegAddrWidth-1:0] MemWbRd,
    input  logic [DataWidth-1:0]    MemWbData,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [DataWidth-1:0]    ALUX,
    output logic [DataWidth-1:0]    ALUY,
    output logic [3:0]              ALUControl,
    output logic [DataWidth-1:0]    StoreData,
    output logic [RegAddrWidth-1:0] Dest,
    output logic                    RegWrite,
    output logic                    MemRead,
    output logic                    MemWrite
);

    logic                    valid_q, valid_d;
    logic [DataWidth-1:0]    rs_data_q, rt_data_q;
    logic [RegAddrWidth-1:0] rs_q, rt_q, rd_q;
    logic [15:0]             imm_q;
    logic [4:0]              shamt_q;
    logic [3:0]              alu_ctrl_q;
    logic                    alu_src_imm_q, sign_ext_q, is_shift_q;
    logic                    reg_write_q, mem_read_q, mem_write_q;

    logic                    hazard, accept, load, out_valid;
    logic [DataWidth-1:0]    fwd_rs, fwd_rt, imm_ext;

    assign hazard = valid_q && ExMemRegWrite && ExMemMemRead
                 && (ExMemRd != RegAddrWidth'(ZERO_REG))
                 && ((ExMemRd == rs_q) || (ExMemRd == rt_q));

    assign out_valid = valid_q && !hazard;
    assign InReady   = !valid_q || (OutReady && !hazard);
    assign accept    = InValid && InReady;
    assign load      = accept && !Flush;

    always_comb begin
        valid_d = valid_q;
        if (Flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_valid && OutReady) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            shamt_q       <= '0;
            alu_ctrl_q    <= AluAdd;
            alu_src_imm_q <= 1'b0;
            sign_ext_q    <= 1'b0;
            is_shift_q    <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else if (load) begin
            rs_data_q     <= RsData;
            rt_data_q     <= RtData;
            rs_q          <= Rs;
            rt_q          <= Rt;
            rd_q          <= Rd;
            imm_q         <= Imm16;
            shamt_q       <= Shamt;
            alu_ctrl_q    <= InALUControl;
            alu_src_imm_q <= ALUSrcImm;
            sign_ext_q    <= SignExt;
            is_shift_q    <= IsShift;
            reg_write_q   <= InRegWrite;
            mem_read_q    <= InMemRead;
            mem_write_q   <= InMemWrite;
        end
    end

    forward_mux #(
        .DataWidth   (DataWidth),
        .RegAddrWidth(RegAddrWidth)
    ) u_fwd_rs (
        .src_i             (rs_q),
        .reg_data_i        (rs_data_q),
        .ex_mem_reg_write_i(ExMemRegWrite),
        .ex_mem_mem_read_i (ExMemMemRead),
        .ex_mem_rd_i       (ExMemRd),
        .ex_mem_result_i   (ExMemResult),
        .mem_wb_reg_write_i(MemWbRegWrite),
        .mem_wb_rd_i       (MemWbRd),
        .mem_wb_data_i     (MemWbData),
        .fwd_data_o        (fwd_rs)
    );

    forward_mux #(
        .DataWidth   (DataWidth),
        .RegAddrWidth(RegAddrWidth)
    ) u_fwd_rt (
        .src_i             (rt_q),
        .reg_data_i        (rt_data_q),
        .ex_mem_reg_write_i(ExMemRegWrite),
        .ex_mem_mem_read_i (ExMemMemRead),
        .ex_mem_rd_i       (ExMemRd),
        .ex_mem_result_i   (ExMemResult),
        .mem_wb_reg_write_i(MemWbRegWrite),
        .mem_wb_rd_i       (MemWbRd),
        .mem_wb_data_i     (MemWbData),
        .fwd_data_o        (fwd_rt)
    );

    assign imm_ext = {{(DataWidth-16){sign_ext_q & imm_q[15]}}, imm_q};

    // Shift amount is presented in the shamt field position, bits [10:6].
    assign ALUX = is_shift_q ? {{(DataWidth-11){1'b0}}, shamt_q, 6'b0} : fwd_rs;
    assign ALUY = alu_src_imm_q ? imm_ext : fwd_rt;

    assign OutValid   = out_valid;
    assign ALUControl = alu_ctrl_q;
    assign StoreData  = fwd_rt;
    assign Dest       = rd_q;
    assign RegWrite   = reg_write_q && out_valid;
    assign MemRead    = mem_read_q && out_valid;
    assign MemWrite   = mem_write_q && out_valid;

endmodule
